// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: drives per-stage select codes,
// resolves load-use / mispredict / memory-wait hazards and runs the debug halt drain.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int DRAIN_CYC   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_rd_wren,
    input  logic             i_ex_is_load,
    input  logic             i_ex_mispred,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    input  logic             i_halt_req,
    output logic [1:0]       o_pc_sel,
    output logic [1:0]       o_if_id_sel,
    output logic [1:0]       o_id_ex_sel,
    output logic [1:0]       o_ex_mem_sel,
    output logic [1:0]       o_mem_wb_sel,
    output logic             o_halt_ack,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(MEM_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYC);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_HOLD = 2'b01;
    localparam logic [1:0] SEL_CLR  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d, drain_inc;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       memwait, load_use, mispred, flush_take;
    logic [1:0] pc_sel, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel;

    always_comb begin
        memwait  = i_mem_req & ~i_mem_ack;
        load_use = i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) &
                   ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
                    (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));
        mispred  = i_ex_mispred & ~memwait;
        drain_inc = (drain_cnt_q == DRAIN_MAX) ? drain_cnt_q : drain_cnt_q + DW'(1);
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        mem_timeout_d = mem_timeout_q;
        flush_take    = 1'b0;
        pc_sel        = SEL_LOAD;
        if_id_sel     = SEL_LOAD;
        id_ex_sel     = SEL_LOAD;
        ex_mem_sel    = SEL_LOAD;
        mem_wb_sel    = SEL_LOAD;

        case (state_q)
            ST_RUN: begin
                drain_cnt_d = '0;
                if (memwait) begin
                    pc_sel     = SEL_HOLD;
                    if_id_sel  = SEL_HOLD;
                    id_ex_sel  = SEL_HOLD;
                    ex_mem_sel = SEL_HOLD;
                    mem_wb_sel = SEL_CLR;
                    state_d    = ST_MEMWAIT;
                end else begin
                    // Wrong-path ID instruction makes any load-use stall moot.
                    if (mispred) begin
                        if_id_sel  = SEL_CLR;
                        id_ex_sel  = SEL_CLR;
                        flush_take = 1'b1;
                    end else if (load_use) begin
                        pc_sel    = SEL_HOLD;
                        if_id_sel = SEL_HOLD;
                        id_ex_sel = SEL_CLR;
                    end
                    if (i_halt_req) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_MEMWAIT: begin
                if (i_mem_ack) begin
                    tmo_cnt_d = '0;
                    state_d   = i_halt_req ? ST_DRAIN : ST_RUN;
                end else begin
                    pc_sel        = SEL_HOLD;
                    if_id_sel     = SEL_HOLD;
                    id_ex_sel     = SEL_HOLD;
                    ex_mem_sel    = SEL_HOLD;
                    mem_wb_sel    = SEL_CLR;
                    tmo_cnt_d     = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
                    mem_timeout_d = mem_timeout_q | (tmo_cnt_d == TMO_MAX);
                end
            end

            ST_DRAIN: begin
                pc_sel    = SEL_HOLD;
                if_id_sel = SEL_CLR;
                if (memwait) begin
                    if_id_sel  = SEL_HOLD;
                    id_ex_sel  = SEL_HOLD;
                    ex_mem_sel = SEL_HOLD;
                    mem_wb_sel = SEL_CLR;
                    state_d    = ST_MEMWAIT;
                end else begin
                    if (mispred) begin
                        pc_sel      = SEL_LOAD;
                        id_ex_sel   = SEL_CLR;
                        flush_take  = 1'b1;
                        drain_cnt_d = drain_inc;
                    end else if (load_use) begin
                        if_id_sel = SEL_HOLD;
                        id_ex_sel = SEL_CLR;
                    end else begin
                        drain_cnt_d = drain_inc;
                    end
                    if (!i_halt_req) begin
                        state_d = ST_RUN;
                    end else if (drain_cnt_d == DRAIN_MAX) begin
                        state_d = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                pc_sel     = SEL_HOLD;
                if_id_sel  = SEL_HOLD;
                id_ex_sel  = SEL_HOLD;
                ex_mem_sel = SEL_HOLD;
                mem_wb_sel = SEL_HOLD;
                if (!i_halt_req) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if ((pc_sel == SEL_HOLD) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_take && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Reset forces the whole pipe to bubbles with the PC frozen.
    always_comb begin
        if (!i_rst_n) begin
            o_pc_sel     = SEL_HOLD;
            o_if_id_sel  = SEL_CLR;
            o_id_ex_sel  = SEL_CLR;
            o_ex_mem_sel = SEL_CLR;
            o_mem_wb_sel = SEL_CLR;
        end else begin
            o_pc_sel     = pc_sel;
            o_if_id_sel  = if_id_sel;
            o_id_ex_sel  = id_ex_sel;
            o_ex_mem_sel = ex_mem_sel;
            o_mem_wb_sel = mem_wb_sel;
        end
        o_halt_ack = i_rst_n & (state_q == ST_HALTED);
    end

    assign o_mem_timeout = mem_timeout_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: two controller instances (default and small-counter/short-timeout) share
// directed and random stimulus; a rule-level model supplies every expected value.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, ex_rd;
    logic rs1_used, rs2_used, ex_rd_wren, ex_is_load, ex_mispred;
    logic mem_req, mem_ack, halt_req;

    logic [1:0]  b_pc, b_ifid, b_idex, b_exmem, b_memwb;
    logic        b_ack, b_to;
    logic [31:0] b_stall, b_flush;
    logic [1:0]  s_pc, s_ifid, s_idex, s_exmem, s_memwb;
    logic        s_ack, s_to;
    logic [3:0]  s_stall, s_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_big (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_ex_rd_addr(ex_rd), .i_ex_rd_wren(ex_rd_wren), .i_ex_is_load(ex_is_load),
        .i_ex_mispred(ex_mispred), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
        .i_halt_req(halt_req),
        .o_pc_sel(b_pc), .o_if_id_sel(b_ifid), .o_id_ex_sel(b_idex),
        .o_ex_mem_sel(b_exmem), .o_mem_wb_sel(b_memwb),
        .o_halt_ack(b_ack), .o_mem_timeout(b_to),
        .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(2), .DRAIN_CYC(4)) u_small (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_ex_rd_addr(ex_rd), .i_ex_rd_wren(ex_rd_wren), .i_ex_is_load(ex_is_load),
        .i_ex_mispred(ex_mispred), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
        .i_halt_req(halt_req),
        .o_pc_sel(s_pc), .o_if_id_sel(s_ifid), .o_id_ex_sel(s_idex),
        .o_ex_mem_sel(s_exmem), .o_mem_wb_sel(s_memwb),
        .o_halt_ack(s_ack), .o_mem_timeout(s_to),
        .o_stall_cnt(s_stall), .o_flush_cnt(s_flush)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: modes and counters as plain integers.
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;
    int     st, nst, drain, ndrain, tcnt, ntcnt;
    bit     to_b, to_s, flush_inc, e_ack;
    longint stall_b, stall_s, flush_b, flush_s;
    int     e [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_e(input int a, input int b, input int c, input int d, input int f);
        e[0] = a; e[1] = b; e[2] = c; e[3] = d; e[4] = f;
    endtask

    task automatic model_reset();
        st = M_RUN; drain = 0; tcnt = 0; to_b = 0; to_s = 0;
        stall_b = 0; stall_s = 0; flush_b = 0; flush_s = 0;
    endtask

    task automatic model_comb();
        bit mw, lu, mp;
        mw = mem_req && !mem_ack;
        lu = ex_is_load && ex_rd_wren && (ex_rd != 0) &&
             ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
        mp = ex_mispred && !mw;
        nst = st; ndrain = drain; ntcnt = tcnt; flush_inc = 0;
        e_ack = (st == M_HALT);
        case (st)
            M_RUN: begin
                ndrain = 0;
                if (mw) begin set_e(1, 1, 1, 1, 3); nst = M_WAIT; end
                else begin
                    if (mp) begin set_e(0, 3, 3, 0, 0); flush_inc = 1; end
                    else if (lu) set_e(1, 1, 3, 0, 0);
                    else set_e(0, 0, 0, 0, 0);
                    if (halt_req) nst = M_DRAIN;
                end
            end
            M_WAIT: begin
                if (mem_ack) begin
                    set_e(0, 0, 0, 0, 0); ntcnt = 0;
                    nst = halt_req ? M_DRAIN : M_RUN;
                end else begin
                    set_e(1, 1, 1, 1, 3); ntcnt = tcnt + 1;
                end
            end
            M_DRAIN: begin
                if (mw) begin set_e(1, 1, 1, 1, 3); nst = M_WAIT; end
                else begin
                    if (mp) begin set_e(0, 3, 3, 0, 0); ndrain++; flush_inc = 1; end
                    else if (lu) set_e(1, 1, 3, 0, 0);
                    else begin set_e(1, 3, 0, 0, 0); ndrain++; end
                    if (!halt_req) nst = M_RUN;
                    else if (ndrain >= 4) nst = M_HALT;
                end
            end
            default: begin
                set_e(1, 1, 1, 1, 1);
                if (!halt_req) nst = M_RUN;
            end
        endcase
    endtask

    task automatic model_commit();
        if (e[0] == 1) begin
            if (stall_b < 64'hFFFF_FFFF) stall_b++;
            if (stall_s < 15) stall_s++;
        end
        if (flush_inc) begin
            if (flush_b < 64'hFFFF_FFFF) flush_b++;
            if (flush_s < 15) flush_s++;
        end
        if (ntcnt >= 64) to_b = 1;
        if (ntcnt >= 2) to_s = 1;
        st = nst; drain = ndrain; tcnt = ntcnt;
    endtask

    task automatic compare_all();
        chk("big_pc",    {30'd0, b_pc},    e[0]);
        chk("big_ifid",  {30'd0, b_ifid},  e[1]);
        chk("big_idex",  {30'd0, b_idex},  e[2]);
        chk("big_exmem", {30'd0, b_exmem}, e[3]);
        chk("big_memwb", {30'd0, b_memwb}, e[4]);
        chk("big_ack",   {31'd0, b_ack},   {31'd0, e_ack});
        chk("big_to",    {31'd0, b_to},    {31'd0, to_b});
        chk("big_stall", b_stall, stall_b[31:0]);
        chk("big_flush", b_flush, flush_b[31:0]);
        chk("sm_sels",   {22'd0, s_pc, s_ifid, s_idex, s_exmem, s_memwb},
            {22'd0, 2'(e[0]), 2'(e[1]), 2'(e[2]), 2'(e[3]), 2'(e[4])});
        chk("sm_ack",    {31'd0, s_ack},   {31'd0, e_ack});
        chk("sm_to",     {31'd0, s_to},    {31'd0, to_s});
        chk("sm_stall",  {28'd0, s_stall}, stall_s[31:0]);
        chk("sm_flush",  {28'd0, s_flush}, flush_s[31:0]);
    endtask

    // Called right after a falling edge with inputs already applied.
    task automatic cycle();
        #2;
        model_comb();
        compare_all();
        @(negedge clk);
        model_commit();
    endtask

    task automatic idle_inputs();
        rs1 = 0; rs2 = 0; ex_rd = 0; rs1_used = 0; rs2_used = 0;
        ex_rd_wren = 0; ex_is_load = 0; ex_mispred = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"},  {30'd0, b_pc}, 32'd1);
        chk({tag, "_stg"}, {24'd0, b_ifid, b_idex, b_exmem, b_memwb}, 32'hFF);
        chk({tag, "_sm"},  {22'd0, s_pc, s_ifid, s_idex, s_exmem, s_memwb}, 32'h1FF);
        chk({tag, "_ack"}, {30'd0, b_ack, s_ack}, 32'd0);
        chk({tag, "_cnt"}, b_stall | b_flush | {28'd0, s_stall | s_flush}, 32'd0);
        chk({tag, "_to"},  {30'd0, b_to, s_to}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        halt_req = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        #1 check_reset_outputs("rst0");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 5; i++) cycle();

        // Load-use on rs1 = rd = 5: one bubble
        ex_is_load = 1; ex_rd_wren = 1; ex_rd = 5; rs1 = 5; rs1_used = 1;
        cycle();
        idle_inputs();
        chk("lu_stall_cnt", b_stall, 32'd1);
        cycle();
        // rd = x0 never stalls
        ex_is_load = 1; ex_rd_wren = 1; ex_rd = 0; rs1 = 0; rs1_used = 1;
        cycle();
        idle_inputs();
        chk("lu_x0_stall_cnt", b_stall, 32'd1);
        // Mispredict coincident with load-use
        ex_is_load = 1; ex_rd_wren = 1; ex_rd = 7; rs2 = 7; rs2_used = 1; ex_mispred = 1;
        cycle();
        idle_inputs();
        chk("mp_flush_cnt", b_flush, 32'd1);
        chk("mp_stall_cnt", b_stall, 32'd1);

        // Memory access acknowledged on the fourth cycle
        mem_req = 1;
        for (int i = 0; i < 3; i++) cycle();
        mem_ack = 1;
        cycle();
        idle_inputs();
        cycle();
        chk("mw_stall_cnt", b_stall, 32'd4);
        chk("mw_small_to", {31'd0, s_to}, 32'd1);
        chk("mw_big_to", {31'd0, b_to}, 32'd0);

        // Halt from RUN: one RUN cycle, four drain cycles, then frozen
        halt_req = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("halt_ack", {31'd0, b_ack}, 32'd1);
        for (int i = 0; i < 15; i++) cycle();
        chk("sm_stall_sat", {28'd0, s_stall}, 32'd15);
        halt_req = 0;
        cycle();
        cycle();

        // Halt raised while memory is busy
        halt_req = 1; mem_req = 1;
        cycle();
        cycle();
        mem_ack = 1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();
        chk("halt_after_mw", {31'd0, b_ack}, 32'd1);
        halt_req = 0;
        cycle();
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            rs1_used   = 1'($urandom_range(0, 1));
            rs2_used   = 1'($urandom_range(0, 1));
            ex_rd_wren = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_mispred = ($urandom_range(0, 9) == 0);
            mem_req    = ($urandom_range(0, 6) == 0) || (st == M_WAIT);
            mem_ack    = ($urandom_range(0, 4) < 2);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            cycle();
        end
        idle_inputs();
        halt_req = 0;
        cycle();
        chk("to_sticky", {31'd0, s_to}, 32'd1);

        // Asynchronous reset mid-cycle
        #2 rst_n = 0;
        #1 check_reset_outputs("rst1");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
